// File: rtl/vmsu_mac_accum_if.sv
// Product-stream / result-stream bundle for vmsu_mac_accum.
// master: upstream multiplier and downstream consumer side.
// slave: the accumulator itself.
interface vmsu_mac_accum_if #(
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 8
);

   // product beat stream from the multiplier output register
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_product;
   logic             in_signed;
   logic             in_last;

   // dot-product result stream to the next consumer
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_product, in_signed, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_product, in_signed, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );

endinterface

// File: rtl/vmsu_mac_accum.sv
// Accumulate stage of the Vedic MAC: sums the 16-bit product stream of a
// vector into an ACC_W-bit accumulator and hands the dot product, beat count
// and sticky overflow flag downstream over valid/ready.
// Optional build macro VMSU_ACC_SAT_EN: every add clamps instead of wrapping.
module vmsu_mac_accum #(
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   vmsu_mac_accum_if.slave   bus
);

   localparam int unsigned EXT_W = ACC_W - 16;
   localparam int unsigned MSB   = ACC_W - 1;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             mode;
   logic             ovf;

   logic             in_ready_q;
   logic             out_valid_q;
   logic [ACC_W-1:0] out_acc_q;
   logic [CNT_W-1:0] out_count_q;
   logic             out_ovf_q;

   logic             accept_c;
   logic             first_c;
   logic             mode_c;
   logic [ACC_W-1:0] ext_c;
   logic [ACC_W:0]   sum_w_c;
   logic [ACC_W-1:0] sum_c;
   logic             ovf_c;
   logic [CNT_W-1:0] cnt_inc_c;

   // Extend the product per vector mode, add, detect overflow, bump count
   always_comb begin
      accept_c  = bus.in_valid && in_ready_q;
      // cnt saturates and never wraps, so zero identifies the first beat
      first_c   = (cnt == '0);
      mode_c    = first_c ? bus.in_signed : mode;
      ext_c     = mode_c ? {{EXT_W{bus.in_product[15]}}, bus.in_product}
                         : {{EXT_W{1'b0}}, bus.in_product};
      sum_w_c   = {1'b0, acc} + {1'b0, ext_c};
      sum_c     = sum_w_c[ACC_W-1:0];
      if (mode_c) begin
         ovf_c = (acc[MSB] == ext_c[MSB]) && (sum_w_c[MSB] != acc[MSB]);
      end else begin
         ovf_c = sum_w_c[ACC_W];
      end
`ifdef VMSU_ACC_SAT_EN
      // clamp toward the side the operands pointed; unsigned only overflows up
      if (ovf_c) begin
         if (mode_c) begin
            sum_c = acc[MSB] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            sum_c = '1;
         end
      end
`endif
      cnt_inc_c = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   end

   // ACCUM/HOLD control, accumulator state and registered result outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         mode        <= 1'b0;
         ovf         <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               if (accept_c) begin
                  if (first_c) begin
                     mode <= bus.in_signed;
                  end
                  if (bus.in_last) begin
                     out_acc_q   <= sum_c;
                     out_count_q <= cnt_inc_c;
                     out_ovf_q   <= ovf | ovf_c;
                     acc         <= '0;
                     cnt         <= '0;
                     ovf         <= 1'b0;
                     mode        <= 1'b0;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     acc <= sum_c;
                     cnt <= cnt_inc_c;
                     ovf <= ovf | ovf_c;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= ACCUM;
               end
            end
            default: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               state       <= ACCUM;
            end
         endcase
      end
   end

   // Drive the bus from the registered copies
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_count = out_count_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vmsu_mac_accum.sv
// Directed bench for vmsu_mac_accum: a 24-bit / 8-bit-count instance for the
// functional cases and a 17-bit / 2-bit-count instance for overflow and count
// saturation.
module tb_vmsu_mac_accum;

`ifdef VMSU_ACC_SAT_EN
   localparam logic [31:0] EXP_UOVF = 32'h1FFFF;
   localparam logic [31:0] EXP_SOVF = 32'h10000;
`else
   localparam logic [31:0] EXP_UOVF = 32'h0FFFD;
   localparam logic [31:0] EXP_SOVF = 32'h08000;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   vmsu_mac_accum_if #(.ACC_W(24), .CNT_W(8)) ia ();
   vmsu_mac_accum_if #(.ACC_W(17), .CNT_W(2)) ib ();

   vmsu_mac_accum #(.ACC_W(24), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   vmsu_mac_accum #(.ACC_W(17), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   // One comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one beat from a negedge, wait (bounded) for in_ready, return at the negedge after acceptance
   task automatic beat(input bit sel_b, input logic [15:0] p, input logic s, input logic l);
      int   n;
      logic rd;
      n = 0;
      if (sel_b) begin
         ib.in_valid = 1'b1; ib.in_product = p; ib.in_signed = s; ib.in_last = l;
      end else begin
         ia.in_valid = 1'b1; ia.in_product = p; ia.in_signed = s; ia.in_last = l;
      end
      rd = sel_b ? ib.in_ready : ia.in_ready;
      while (!rd && n < 20) begin
         @(negedge clk);
         n++;
         rd = sel_b ? ib.in_ready : ia.in_ready;
      end
      chk("in_ready_wait", 32'(rd), 32'd1);
      @(negedge clk);
      ia.in_valid = 1'b0;
      ib.in_valid = 1'b0;
   endtask

   // Check a held result, then release it and check the return to ACCUM
   task automatic result(input bit sel_b, input string tag, input logic [31:0] acc,
                         input logic [31:0] cnt, input logic [31:0] ovf);
      if (sel_b) begin
         chk({tag, "_valid"}, 32'(ib.out_valid), 32'd1);
         chk({tag, "_rdy0"},  32'(ib.in_ready),  32'd0);
         chk({tag, "_acc"},   32'(ib.out_acc),   acc);
         chk({tag, "_cnt"},   32'(ib.out_count), cnt);
         chk({tag, "_ovf"},   32'(ib.out_ovf),   ovf);
         ib.out_ready = 1'b1;
         @(negedge clk);
         ib.out_ready = 1'b0;
         chk({tag, "_pop_valid"}, 32'(ib.out_valid), 32'd0);
         chk({tag, "_pop_rdy"},   32'(ib.in_ready),  32'd1);
      end else begin
         chk({tag, "_valid"}, 32'(ia.out_valid), 32'd1);
         chk({tag, "_rdy0"},  32'(ia.in_ready),  32'd0);
         chk({tag, "_acc"},   32'(ia.out_acc),   acc);
         chk({tag, "_cnt"},   32'(ia.out_count), cnt);
         chk({tag, "_ovf"},   32'(ia.out_ovf),   ovf);
         ia.out_ready = 1'b1;
         @(negedge clk);
         ia.out_ready = 1'b0;
         chk({tag, "_pop_valid"}, 32'(ia.out_valid), 32'd0);
         chk({tag, "_pop_rdy"},   32'(ia.in_ready),  32'd1);
      end
   endtask

   initial begin
      ia.in_valid = 1'b0; ia.in_product = '0; ia.in_signed = 1'b0; ia.in_last = 1'b0; ia.out_ready = 1'b0;
      ib.in_valid = 1'b0; ib.in_product = '0; ib.in_signed = 1'b0; ib.in_last = 1'b0; ib.out_ready = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_a_valid", 32'(ia.out_valid), 32'd0);
      chk("rst_a_rdy",   32'(ia.in_ready),  32'd0);
      chk("rst_a_acc",   32'(ia.out_acc),   32'd0);
      chk("rst_a_cnt",   32'(ia.out_count), 32'd0);
      chk("rst_a_ovf",   32'(ia.out_ovf),   32'd0);
      chk("rst_b_rdy",   32'(ib.in_ready),  32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_rdy", 32'(ia.in_ready), 32'd1);

      // unsigned three-beat vector
      beat(1'b0, 16'hFE01, 1'b0, 1'b0);
      beat(1'b0, 16'hFE01, 1'b0, 1'b0);
      chk("u3_no_early_valid", 32'(ia.out_valid), 32'd0);
      beat(1'b0, 16'hFE01, 1'b0, 1'b1);
      result(1'b0, "u3", 32'h02FA03, 32'd3, 32'd0);

      // signed vector; in_signed on the second beat must be ignored
      beat(1'b0, 16'hFF80, 1'b1, 1'b0);
      beat(1'b0, 16'h4000, 1'b0, 1'b1);
      result(1'b0, "s2", 32'h003F80, 32'd2, 32'd0);

      // same products unsigned; in_signed on the second beat ignored again
      beat(1'b0, 16'hFF80, 1'b0, 1'b0);
      beat(1'b0, 16'h4000, 1'b1, 1'b1);
      result(1'b0, "u2", 32'h013F80, 32'd2, 32'd0);

      // 17-bit unsigned overflow
      beat(1'b1, 16'hFFFF, 1'b0, 1'b0);
      beat(1'b1, 16'hFFFF, 1'b0, 1'b0);
      beat(1'b1, 16'hFFFF, 1'b0, 1'b1);
      result(1'b1, "uovf", EXP_UOVF, 32'd3, 32'd1);

      // 17-bit signed overflow
      beat(1'b1, 16'h8000, 1'b1, 1'b0);
      beat(1'b1, 16'h8000, 1'b1, 1'b0);
      beat(1'b1, 16'h8000, 1'b1, 1'b1);
      result(1'b1, "sovf", EXP_SOVF, 32'd3, 32'd1);

      // 2-bit count saturates at 3 without flagging overflow
      for (int i = 0; i < 5; i++) beat(1'b1, 16'h0001, 1'b0, 1'(i == 4));
      result(1'b1, "csat", 32'd5, 32'd3, 32'd0);

      // single-beat signed vector: -1 sign-extended
      beat(1'b0, 16'hFFFF, 1'b1, 1'b1);
      chk("one_acc", 32'(ia.out_acc),   32'hFFFFFF);
      chk("one_cnt", 32'(ia.out_count), 32'd1);

      // backpressure: beats offered throughout HOLD must not be taken
      ia.in_valid = 1'b1; ia.in_product = 16'h0101; ia.in_signed = 1'b0; ia.in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(ia.out_valid), 32'd1);
         chk("bp_rdy",   32'(ia.in_ready),  32'd0);
         chk("bp_acc",   32'(ia.out_acc),   32'hFFFFFF);
         chk("bp_cnt",   32'(ia.out_count), 32'd1);
      end
      ia.in_valid = 1'b0;
      ia.out_ready = 1'b1;
      @(negedge clk);
      ia.out_ready = 1'b0;
      chk("bp_rel_rdy",   32'(ia.in_ready),  32'd1);
      chk("bp_rel_valid", 32'(ia.out_valid), 32'd0);
      beat(1'b0, 16'h0007, 1'b0, 1'b1);
      result(1'b0, "bp_next", 32'd7, 32'd1, 32'd0);

      // reset mid-vector clears the previously held result immediately
      beat(1'b0, 16'h0010, 1'b0, 1'b0);
      beat(1'b0, 16'h0020, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("mrst_acc",   32'(ia.out_acc),   32'd0);
      chk("mrst_cnt",   32'(ia.out_count), 32'd0);
      chk("mrst_ovf",   32'(ia.out_ovf),   32'd0);
      chk("mrst_valid", 32'(ia.out_valid), 32'd0);
      chk("mrst_rdy",   32'(ia.in_ready),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      beat(1'b0, 16'h0005, 1'b0, 1'b1);
      result(1'b0, "mrst_next", 32'd5, 32'd1, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
